// File: rtl/axis_out_requant_pkg.sv
// Shared defaults, saturation bounds and lane slicing for the axis_out_requant block.
package axis_out_requant_pkg;

    localparam int unsigned RowsDefault      = 4;
    localparam int unsigned YBitsDefault     = 32;
    localparam int unsigned YOutBitsDefault  = 8;
    localparam int unsigned ShiftBitsDefault = 5;

    function automatic int out_max(int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int out_min(int unsigned w);
        return -(1 << (w - 1));
    endfunction

    // Lane i of a packed bus of w-bit lanes starts at bit i*w.
    function automatic int unsigned lane_lsb(int unsigned lane, int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/axis_out_requant_lane.sv
// requant_lane: one lane of round-half-up, arithmetic shift and saturation, two registers deep.
// With OUT_RELU_EN defined, negative saturated results are clamped to zero.
module requant_lane
    import axis_out_requant_pkg::*;
#(
    parameter int unsigned Y_BITS     = YBitsDefault,
    parameter int unsigned Y_OUT_BITS = YOutBitsDefault,
    parameter int unsigned SHIFT_BITS = ShiftBitsDefault
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  in_valid_i,
    input  logic                  mid_valid_i,
    input  logic [SHIFT_BITS-1:0] shift_eff_i,
    input  logic [SHIFT_BITS-1:0] shift_mid_i,
    input  logic [Y_BITS-1:0]     x_i,
    output logic [Y_OUT_BITS-1:0] y_o
);

    localparam logic signed [Y_BITS:0] SatMax = (Y_BITS + 1)'(out_max(Y_OUT_BITS));
    localparam logic signed [Y_BITS:0] SatMin = (Y_BITS + 1)'(out_min(Y_OUT_BITS));
    localparam logic signed [Y_BITS:0] One    = (Y_BITS + 1)'(1);

    logic signed [Y_BITS:0]  sum_d, sum_q, shifted;
    logic [Y_OUT_BITS-1:0]   y_d, y_q;

    // One extra bit keeps the rounding offset from overflowing the largest positive input.
    always_comb begin
        sum_d = {x_i[Y_BITS-1], x_i};
        if (shift_eff_i != '0) begin
            sum_d = sum_d + (One <<< (shift_eff_i - 1'b1));
        end
    end

    always_comb begin
        shifted = sum_q >>> shift_mid_i;
        if (shifted > SatMax) begin
            y_d = SatMax[Y_OUT_BITS-1:0];
        end else if (shifted < SatMin) begin
            y_d = SatMin[Y_OUT_BITS-1:0];
        end else begin
            y_d = shifted[Y_OUT_BITS-1:0];
        end
`ifdef OUT_RELU_EN
        if (y_d[Y_OUT_BITS-1]) begin
            y_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q <= '0;
            y_q   <= '0;
        end else if (en_i) begin
            if (in_valid_i) begin
                sum_q <= sum_d;
            end
            if (mid_valid_i) begin
                y_q <= y_d;
            end
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/axis_out_requant.sv
// Requantizes ROWS signed accumulator lanes per beat behind a 2-stage globally stalled pipeline.
// Define OUT_RELU_EN to clamp negative outputs to zero in every lane.
module axis_out_requant
    import axis_out_requant_pkg::*;
#(
    parameter int unsigned ROWS       = RowsDefault,
    parameter int unsigned Y_BITS     = YBitsDefault,
    parameter int unsigned Y_OUT_BITS = YOutBitsDefault,
    parameter int unsigned SHIFT_BITS = ShiftBitsDefault
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    output logic                       s_ready,
    input  logic                       s_valid,
    input  logic                       s_last,
    input  logic [ROWS*Y_BITS-1:0]     s_data,
    input  logic [SHIFT_BITS-1:0]      cfg_shift,
    input  logic                       m_ready,
    output logic                       m_valid,
    output logic                       m_last,
    output logic [ROWS*Y_OUT_BITS-1:0] m_data
);

    localparam int unsigned ShiftMax = Y_BITS - 1;

    logic                  en, accept;
    logic                  in_pkt_q, in_pkt_d;
    logic [SHIFT_BITS-1:0] shift_q, shift_d, shift_clamped, shift_eff, shift_mid_q;
    logic                  mid_valid_q, mid_last_q, m_valid_q, m_last_q;

    assign en      = m_ready || !m_valid_q;
    assign s_ready = en;
    assign accept  = s_valid && en;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

    // The shift is latched on a packet's first beat; later cfg_shift changes are ignored.
    always_comb begin
        shift_clamped = cfg_shift;
        if (32'(cfg_shift) > ShiftMax) begin
            shift_clamped = SHIFT_BITS'(ShiftMax);
        end
        shift_eff = in_pkt_q ? shift_q : shift_clamped;
        in_pkt_d  = in_pkt_q;
        shift_d   = shift_q;
        if (accept) begin
            in_pkt_d = !s_last;
            shift_d  = shift_eff;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            in_pkt_q    <= 1'b0;
            shift_q     <= '0;
            mid_valid_q <= 1'b0;
            mid_last_q  <= 1'b0;
            shift_mid_q <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
            shift_q  <= shift_d;
            if (en) begin
                mid_valid_q <= accept;
                mid_last_q  <= s_last;
                shift_mid_q <= shift_eff;
                m_valid_q   <= mid_valid_q;
                m_last_q    <= mid_last_q;
            end
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        requant_lane #(
            .Y_BITS    (Y_BITS),
            .Y_OUT_BITS(Y_OUT_BITS),
            .SHIFT_BITS(SHIFT_BITS)
        ) u_lane (
            .clk_i      (aclk),
            .rst_ni     (aresetn),
            .en_i       (en),
            .in_valid_i (accept),
            .mid_valid_i(mid_valid_q),
            .shift_eff_i(shift_eff),
            .shift_mid_i(shift_mid_q),
            .x_i        (s_data[lane_lsb(i, Y_BITS) +: Y_BITS]),
            .y_o        (m_data[lane_lsb(i, Y_OUT_BITS) +: Y_OUT_BITS])
        );
    end

endmodule

// File: tb/tb_axis_out_requant.sv
// Self-checking bench for axis_out_requant (ROWS=4, Y_BITS=32, Y_OUT_BITS=8, SHIFT_BITS=5).
module tb_axis_out_requant;

    localparam int ROWS = 4;
    localparam int YB   = 32;
    localparam int YO   = 8;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic [ROWS*YB-1:0] s_data = '0;
    logic [4:0]        cfg_shift = '0;
    logic              m_ready = 1'b1;
    logic              s_ready, m_valid, m_last;
    logic [ROWS*YO-1:0] m_data;

    axis_out_requant #(
        .ROWS      (ROWS),
        .Y_BITS    (YB),
        .Y_OUT_BITS(YO),
        .SHIFT_BITS(5)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_ready  (s_ready),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_data   (s_data),
        .cfg_shift(cfg_shift),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_data   (m_data)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;
    logic [ROWS*YO-1:0] obs_data[$];
    logic               obs_last[$];
    logic [ROWS*YO-1:0] exp_data[$];
    logic               exp_last[$];
    bit                 tb_in_pkt;
    int                 tb_shift;
    bit                 drv_done;

    // Reference: floor(x / 2^s + 0.5) == floor((2x + 2^s) / 2^(s+1)), then clip.
    function automatic logic [YO-1:0] ref_lane(longint x, int s);
        longint r;
        r = (2 * x + (longint'(1) <<< s)) >>> (s + 1);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`ifdef OUT_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[YO-1:0];
    endfunction

    function automatic logic [ROWS*YO-1:0] ref_beat(logic [ROWS*YB-1:0] d, int s);
        logic [ROWS*YO-1:0] o;
        for (int i = 0; i < ROWS; i++) begin
            o[i*YO +: YO] = ref_lane(longint'($signed(d[i*YB +: YB])), s);
        end
        return o;
    endfunction

    always @(negedge aclk) begin
        if (aresetn && m_valid && m_ready) begin
            obs_data.push_back(m_data);
            obs_last.push_back(m_last);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_queues();
        obs_data.delete();
        obs_last.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_valid = 1'b0;
        step();
        step();
        aresetn   = 1'b1;
        tb_in_pkt = 1'b0;
        tb_shift  = 0;
        clear_queues();
    endtask

    // Presents one beat, waits (bounded) for acceptance and records the expected output.
    task automatic send_beat(input logic [ROWS*YB-1:0] d, input logic last, input logic [4:0] sh);
        int waited = 0;
        s_valid   = 1'b1;
        s_data    = d;
        s_last    = last;
        cfg_shift = sh;
        @(negedge aclk);
        while (!s_ready && waited < 200) begin
            @(negedge aclk);
            waited++;
        end
        if (!s_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: s_ready=%0b required 1", s_ready);
        end else begin
            if (!tb_in_pkt) tb_shift = (int'(sh) > YB - 1) ? YB - 1 : int'(sh);
            tb_in_pkt = !last;
            exp_data.push_back(ref_beat(d, tb_shift));
            exp_last.push_back(last);
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while (obs_data.size() < exp_data.size() && c < 100) begin
            step();
            c++;
        end
        repeat (4) step();
    endtask

    task automatic test_reset();
        m_ready = 1'b1;
        do_reset();
        @(negedge aclk);
        n_vec++;
        if (m_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid);
        end
        n_vec++;
        if (m_last !== 1'b0) begin
            n_err++; $display("FAIL reset_m_last: got %b want 0", m_last);
        end
        n_vec++;
        if (m_data !== '0) begin
            n_err++; $display("FAIL reset_m_data: got %h want 0", m_data);
        end
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_s_ready: got %b want 1", s_ready);
        end
        step();
    endtask

    task automatic test_rounding();
        logic [ROWS*YO-1:0] want;
        want = {8'd0, 8'd1, 8'hef, 8'd18};
        clear_queues();
        send_beat({-32'sd8, 32'sd8, -32'sd280, 32'sd280}, 1'b1, 5'd4);
        @(negedge aclk);
        n_vec++;
        if (m_valid !== 1'b0) begin
            n_err++; $display("FAIL round_early_valid: got %b want 0", m_valid);
        end
        @(negedge aclk);
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== want || m_last !== 1'b1) begin
            n_err++;
            $display("FAIL round_out: valid=%b data=%h last=%b want valid=1 data=%h last=1",
                     m_valid, m_data, m_last, want);
        end
        step();
        drain();
    endtask

    task automatic test_saturation();
        logic [ROWS*YO-1:0] want;
`ifdef OUT_RELU_EN
        want = {8'h00, 8'h7f, 8'h00, 8'h7f};
`else
        want = {8'h80, 8'h7f, 8'h80, 8'h7f};
`endif
        clear_queues();
        send_beat({-32'sd128, 32'sd127, -32'sd300, 32'sd300}, 1'b1, 5'd0);
        drain();
        n_vec++;
        if (obs_data.size() != 1) begin
            n_err++; $display("FAIL sat_count: got %0d beats want 1", obs_data.size());
        end else if (obs_data[0] !== want) begin
            n_err++; $display("FAIL sat_data: got %h want %h", obs_data[0], want);
        end
    endtask

    task automatic test_shift_latch();
        logic [ROWS*YO-1:0] want_d[4];
        logic               want_l[4];
        want_d = '{{4{8'd4}}, {4{8'd4}}, {4{8'd4}}, {4{8'd8}}};
        want_l = '{1'b0, 1'b0, 1'b1, 1'b1};
        clear_queues();
        send_beat({4{32'd16}}, 1'b0, 5'd2);
        send_beat({4{32'd16}}, 1'b0, 5'd7);
        send_beat({4{32'd16}}, 1'b1, 5'd7);
        send_beat({4{32'd1024}}, 1'b1, 5'd7);
        drain();
        n_vec++;
        if (obs_data.size() != 4) begin
            n_err++; $display("FAIL latch_count: got %0d beats want 4", obs_data.size());
        end
        for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
            n_vec++;
            if (obs_data[i] !== want_d[i] || obs_last[i] !== want_l[i]) begin
                n_err++;
                $display("FAIL latch_beat%0d: data=%h last=%b want data=%h last=%b",
                         i, obs_data[i], obs_last[i], want_d[i], want_l[i]);
            end
        end
    endtask

    task automatic test_clamp();
        clear_queues();
        send_beat({4{32'h4000_0000}}, 1'b1, 5'd31);
        drain();
        n_vec++;
        if (obs_data.size() != 1 || obs_data[0] !== {4{8'd1}}) begin
            n_err++;
            $display("FAIL clamp_data: beats=%0d data=%h want 1 beat of %h",
                     obs_data.size(), obs_data.size() ? obs_data[0] : '0, {4{8'd1}});
        end
    endtask

    task automatic test_backpressure();
        logic [ROWS*YO-1:0] hold_d;
        logic               hold_v;
        clear_queues();
        m_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    logic [ROWS*YB-1:0] d;
                    for (int i = 0; i < ROWS; i++) d[i*YB +: YB] = 32'(k * 4 + i);
                    send_beat(d, k == 9, 5'd0);
                end
            end
            begin
                repeat (4) step();
                m_ready = 1'b0;
                @(negedge aclk);
                hold_d = m_data;
                hold_v = m_valid;
                repeat (4) begin
                    @(negedge aclk);
                    n_vec++;
                    if (m_data !== hold_d || m_valid !== hold_v) begin
                        n_err++;
                        $display("FAIL stall_hold: data=%h valid=%b want data=%h valid=%b",
                                 m_data, m_valid, hold_d, hold_v);
                    end
                    n_vec++;
                    if (m_valid && s_ready !== 1'b0) begin
                        n_err++; $display("FAIL stall_s_ready: got %b want 0", s_ready);
                    end
                end
                @(posedge aclk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain();
        n_vec++;
        if (obs_data.size() != 10) begin
            n_err++; $display("FAIL bp_count: got %0d beats want 10", obs_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL bp_beat%0d: data=%h last=%b want data=%h last=%b",
                         i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [ROWS*YO-1:0] want;
`ifdef OUT_RELU_EN
        want = {8'd0, 8'd50, 8'd0, 8'd3};
`else
        want = {8'hff, 8'd50, 8'hff, 8'd3};
`endif
        want[31:24] = 8'd0;
        clear_queues();
        m_ready = 1'b1;
        send_beat({4{32'd640}}, 1'b0, 5'd5);
        send_beat({4{32'd640}}, 1'b0, 5'd5);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        @(negedge aclk);
        n_vec++;
        if (m_valid !== 1'b0 || m_data !== '0) begin
            n_err++;
            $display("FAIL midrst_clear: valid=%b data=%h want valid=0 data=0", m_valid, m_data);
        end
        step();
        tb_in_pkt = 1'b0;
        tb_shift  = 0;
        clear_queues();
        send_beat({-32'sd1, 32'sd100, -32'sd3, 32'sd5}, 1'b1, 5'd1);
        drain();
        n_vec++;
        if (obs_data.size() != 1 || obs_data[0] !== want || obs_last[0] !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_new_pkt: beats=%0d data=%h want 1 beat of %h last=1",
                     obs_data.size(), obs_data.size() ? obs_data[0] : '0, want);
        end
    endtask

    task automatic test_random();
        clear_queues();
        drv_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        logic [ROWS*YB-1:0] d;
                        for (int i = 0; i < ROWS; i++) begin
                            if ($urandom_range(0, 1) == 0) d[i*YB +: YB] = $urandom();
                            else d[i*YB +: YB] = 32'(int'($urandom_range(0, 1200)) - 600);
                        end
                        send_beat(d, b == len - 1, 5'($urandom_range(0, 31)));
                        if ($urandom_range(0, 4) == 0) step();
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    step();
                    m_ready = ($urandom_range(0, 3) != 0);
                end
                m_ready = 1'b1;
            end
        join
        drain();
        n_vec++;
        if (obs_data.size() != exp_data.size()) begin
            n_err++;
            $display("FAIL rand_count: got %0d beats want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL rand_beat%0d: data=%h last=%b want data=%h last=%b",
                         i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_shift_latch();
        test_clamp();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
